// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch sequencer and its return stack.
package fetch_pkg;
  localparam int D_DEF        = 12;
  localparam int LW_DEF       = 5;
  localparam int SD_DEF       = 4;
  localparam int END_ADDR_DEF = 256;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET} next_sel_t;
endpackage

// File: rtl/ret_stack.sv
// LIFO of call return addresses; pushes when full and pops when empty are ignored here,
// the caller reports them as stack errors.
module ret_stack
  import fetch_pkg::*;
#(
  parameter int SD = SD_DEF,
  parameter int W  = D_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  logic [W-1:0]  mem [SD];
  logic [PW-1:0] ptr;

  assign full  = (ptr == PW'(SD));
  assign empty = (ptr == '0);
  assign top   = empty ? '0 : mem[AW'(ptr - PW'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[AW'(ptr)] <= data;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Program counter with req/done run handshake, relative or table-based branch targets
// and a hardware call/return stack.
//   state | meaning
//   IDLE  | after reset, PC parked at 0, waiting for req
//   RUN   | fetching, PC advances each non-stalled cycle
//   DONE  | PC reached END_ADDR and is held until the next req
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int D        = D_DEF,
  parameter int LW       = LW_DEF,
  parameter int SD       = SD_DEF,
  parameter int END_ADDR = END_ADDR_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          cond,
  input  logic          jump_en,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic          rel_mode,
  input  logic [7:0]    offset,
  input  logic [LW-1:0] target_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic [D-1:0]  link_addr,
  output logic          busy,
  output logic          done,
  output logic          stack_err
);
  localparam logic [D-1:0] END_PC = D'(END_ADDR);

  state_t       state;
  next_sel_t    sel;
  logic [D-1:0] lut [2**LW];
  logic [D-1:0] pc_inc, target, pc_next, stack_top;
  logic         stack_full, stack_empty, step, start, push, pop, err_set;

  assign step   = (state == RUN) && !stall;
  assign start  = (state != RUN) && req;
  assign pc_inc = prog_ctr + D'(1);
  assign target = rel_mode ? prog_ctr + {{(D-8){offset[7]}}, offset} : lut[target_idx];

  // Strobe priority: ret > call > jump > taken branch > increment.
  always_comb begin
    sel     = SEL_INC;
    err_set = 1'b0;
    if (ret_en) begin
      if (stack_empty) err_set = 1'b1;
      else             sel     = SEL_RET;
    end else if (call_en) begin
      sel     = SEL_CALL;
      err_set = stack_full;
    end else if (jump_en) begin
      sel = SEL_JMP;
    end else if (branch_en && cond) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_RET:                   pc_next = stack_top;
      SEL_CALL, SEL_JMP, SEL_BR: pc_next = target;
      default:                   pc_next = pc_inc;
    endcase
  end

  assign push = step && (sel == SEL_CALL) && !stack_full;
  assign pop  = step && (sel == SEL_RET);

  always_ff @(posedge clk) begin
    if (lut_we) lut[lut_waddr] <= lut_wdata;
  end

  ret_stack #(.SD(SD), .W(D)) u_stack (
    .clk   (clk),
    .rst_n (reset),
    .clear (start),
    .push  (push),
    .pop   (pop),
    .data  (pc_inc),
    .top   (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      link_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            state     <= RUN;
            prog_ctr  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            stack_err <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            prog_ctr <= pc_next;
            if (sel == SEL_CALL || sel == SEL_JMP) link_addr <= pc_inc;
            if (err_set) stack_err <= 1'b1;
            if (pc_next == END_PC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random
// strobes, all compared every cycle against a queue-based behavioural model.
module tb_fetch_sequencer;
  localparam int D = 12, LW = 5, SD = 4, END_ADDR = 256;
  localparam int MASK = (1 << D) - 1;

  logic clk = 1'b0, reset = 1'b0;
  logic req = 1'b0, stall = 1'b0, branch_en = 1'b0, cond = 1'b0, jump_en = 1'b0;
  logic call_en = 1'b0, ret_en = 1'b0, rel_mode = 1'b0, lut_we = 1'b0;
  logic [7:0]    offset = '0;
  logic [LW-1:0] target_idx = '0, lut_waddr = '0;
  logic [D-1:0]  lut_wdata = '0;
  logic [D-1:0]  prog_ctr, link_addr;
  logic          busy, done, stack_err;

  int checks = 0, failures = 0;
  bit chk_on = 1'b0;

  // model state: run/done flags, pc, link, error flag, return stack, table
  bit m_run = 0, m_done = 0, m_err = 0;
  int m_pc = 0, m_link = 0;
  int m_stack[$];
  int m_lut[2**LW];

  fetch_sequencer #(.D(D), .LW(LW), .SD(SD), .END_ADDR(END_ADDR)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .branch_en(branch_en), .cond(cond),
    .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .rel_mode(rel_mode),
    .offset(offset), .target_idx(target_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .prog_ctr(prog_ctr), .link_addr(link_addr), .busy(busy),
    .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int inc, tgt, npc;
    if (!reset) begin
      m_run = 0; m_done = 0; m_err = 0; m_pc = 0; m_link = 0;
      m_stack.delete();
      return;
    end
    if (!m_run) begin
      if (req) begin
        m_run = 1; m_done = 0; m_pc = 0; m_err = 0;
        m_stack.delete();
      end
    end else if (!stall) begin
      inc = (m_pc + 1) & MASK;
      tgt = rel_mode ? ((m_pc + int'($signed(offset))) & MASK) : m_lut[target_idx];
      if (ret_en) begin
        if (m_stack.size() == 0) begin npc = inc; m_err = 1; end
        else npc = m_stack.pop_back();
      end else if (call_en) begin
        m_link = inc;
        if (m_stack.size() == SD) m_err = 1;
        else m_stack.push_back(inc);
        npc = tgt;
      end else if (jump_en) begin
        m_link = inc;
        npc = tgt;
      end else if (branch_en && cond) npc = tgt;
      else npc = inc;
      m_pc = npc;
      if (npc == END_ADDR) begin m_run = 0; m_done = 1; end
    end
    if (lut_we) m_lut[lut_waddr] = lut_wdata;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      checks++;
      if (prog_ctr !== D'(m_pc) || link_addr !== D'(m_link) || busy !== m_run ||
          done !== m_done || stack_err !== m_err) begin
        failures++;
        $display("FAIL cycle_compare t=%0t got pc=%0h link=%0h busy=%0b done=%0b err=%0b required pc=%0h link=%0h busy=%0b done=%0b err=%0b",
                 $time, prog_ctr, link_addr, busy, done, stack_err, m_pc, m_link, m_run, m_done, m_err);
      end
    end
  end

  task automatic expect_val(input string name, input int got, input int mdl, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: dut=%0h required=%0h", name, got, want);
    end
    checks++;
    if (mdl != want) begin
      failures++;
      $display("FAIL %s_model: model=%0h required=%0h", name, mdl, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_in();
    req = 0; branch_en = 0; cond = 0; jump_en = 0; call_en = 0; ret_en = 0;
    rel_mode = 0; lut_we = 0; offset = '0;
  endtask

  task automatic strobe_rel(input bit is_call, input bit is_jump, input bit is_br, input logic [7:0] off);
    call_en = is_call; jump_en = is_jump; branch_en = is_br; cond = is_br;
    rel_mode = 1; offset = off;
    tick();
    clear_in();
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: run did not finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk_on = 1;
    expect_val("rst_pc", prog_ctr, m_pc, 0);
    expect_val("rst_flags", {busy, done, stack_err}, {m_run, m_done, m_err}, 0);
    reset = 1;
    req = 1; tick(); req = 0;
    expect_val("start_pc", prog_ctr, m_pc, 0);
    expect_val("start_busy", busy, m_run, 1);
    repeat (37) tick();
    expect_val("pc37", prog_ctr, m_pc, 37);
    #3 reset = 0;
    #1;
    expect_val("midrst_pc", prog_ctr, m_pc, 0);
    expect_val("midrst_busy", busy, m_run, 0);
    tick(); reset = 1;

    req = 1; tick(); req = 0;
    expect_val("run_pc0", prog_ctr, m_pc, 0);
    tick(); expect_val("run_pc1", prog_ctr, m_pc, 1);
    tick(); expect_val("run_pc2", prog_ctr, m_pc, 2);
    lut_we = 1; lut_waddr = 3; lut_wdata = 12'h0A0; tick(); lut_we = 0;
    tick(); tick();
    expect_val("pc5", prog_ctr, m_pc, 5);
    jump_en = 1; rel_mode = 0; target_idx = 3; tick(); clear_in();
    expect_val("abs_jump_pc", prog_ctr, m_pc, 12'h0A0);
    expect_val("abs_jump_link", link_addr, m_link, 6);
    lut_we = 1; lut_waddr = 3; lut_wdata = 12'h010; jump_en = 1; target_idx = 3; tick(); clear_in();
    expect_val("lut_old_value", prog_ctr, m_pc, 12'h0A0);
    jump_en = 1; target_idx = 3; tick(); clear_in();
    expect_val("lut_new_value", prog_ctr, m_pc, 12'h010);
    expect_val("lut_new_link", link_addr, m_link, 12'h0A1);

    branch_en = 1; rel_mode = 1; offset = 8'hFC; cond = 0; tick(); clear_in();
    expect_val("br_not_taken", prog_ctr, m_pc, 12'h011);
    strobe_rel(0, 1, 0, 8'hFF);
    expect_val("rel_back", prog_ctr, m_pc, 12'h010);
    strobe_rel(0, 0, 1, 8'hFC);
    expect_val("br_taken", prog_ctr, m_pc, 12'h00C);
    strobe_rel(0, 1, 0, 8'hF4);
    expect_val("rel_to_zero", prog_ctr, m_pc, 0);
    strobe_rel(0, 0, 1, 8'hFF);
    expect_val("rel_wrap", prog_ctr, m_pc, 12'hFFF);
    strobe_rel(0, 1, 0, 8'h0B);
    expect_val("rel_wrap_fwd", prog_ctr, m_pc, 10);

    for (int i = 0; i < 4; i++) begin
      strobe_rel(1, 0, 0, 8'd10);
      expect_val("call_pc", prog_ctr, m_pc, 20 + 10 * i);
    end
    strobe_rel(1, 0, 0, 8'd10);
    expect_val("call_full_pc", prog_ctr, m_pc, 60);
    expect_val("call_full_err", stack_err, m_err, 1);
    for (int i = 0; i < 4; i++) begin
      ret_en = 1; tick(); clear_in();
      expect_val("ret_pc", prog_ctr, m_pc, 41 - 10 * i);
    end
    ret_en = 1; tick(); clear_in();
    expect_val("ret_empty_pc", prog_ctr, m_pc, 12);
    expect_val("ret_empty_err", stack_err, m_err, 1);
    strobe_rel(1, 0, 0, 8'd10);
    expect_val("call_again", prog_ctr, m_pc, 22);
    ret_en = 1; call_en = 1; rel_mode = 1; offset = 8'd10; tick(); clear_in();
    expect_val("ret_beats_call", prog_ctr, m_pc, 13);
    ret_en = 1; tick(); clear_in();
    expect_val("no_push_on_ret", prog_ctr, m_pc, 14);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      jump_en = 1; rel_mode = 1; offset = 8'd50; tick();
      expect_val("stall_hold", prog_ctr, m_pc, 14);
    end
    stall = 0; clear_in();
    strobe_rel(1, 0, 0, 8'd1);
    expect_val("call_before_end", prog_ctr, m_pc, 15);
    lut_we = 1; lut_waddr = 9; lut_wdata = 12'd250; tick(); clear_in();
    jump_en = 1; target_idx = 9; tick(); clear_in();
    expect_val("jump_250", prog_ctr, m_pc, 250);
    repeat (5) tick();
    expect_val("pc255", prog_ctr, m_pc, 255);
    expect_val("pc255_done", done, m_done, 0);
    tick();
    expect_val("end_pc", prog_ctr, m_pc, 256);
    expect_val("end_flags", {busy, done}, {m_run, m_done}, 2'b01);
    jump_en = 1; rel_mode = 1; offset = 8'd5; stall = 1; tick(); tick(); clear_in(); stall = 0;
    expect_val("done_hold", prog_ctr, m_pc, 256);
    req = 1; tick(); req = 0;
    expect_val("restart_pc", prog_ctr, m_pc, 0);
    expect_val("restart_flags", {busy, done, stack_err}, {m_run, m_done, m_err}, 3'b100);
    ret_en = 1; tick(); clear_in();
    expect_val("restart_stack_empty", prog_ctr, m_pc, 1);

    for (int i = 0; i < 2**LW; i++) begin
      lut_we = 1; lut_waddr = LW'(i);
      lut_wdata = (i < 8) ? D'(244 + i) : D'($urandom_range(0, MASK));
      tick();
    end
    clear_in();
    for (int n = 0; n < 3000; n++) begin
      req        = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 9) == 0);
      ret_en     = ($urandom_range(0, 7) == 0);
      call_en    = ($urandom_range(0, 7) == 0);
      jump_en    = ($urandom_range(0, 9) == 0);
      branch_en  = ($urandom_range(0, 3) == 0);
      cond       = 1'($urandom_range(0, 1));
      rel_mode   = 1'($urandom_range(0, 1));
      offset     = 8'($urandom_range(0, 255));
      target_idx = LW'($urandom_range(0, 2**LW - 1));
      lut_we     = ($urandom_range(0, 9) == 0);
      lut_waddr  = LW'($urandom_range(0, 2**LW - 1));
      lut_wdata  = ($urandom_range(0, 1) == 1) ? D'($urandom_range(240, 262)) : D'($urandom_range(0, MASK));
      tick();
    end
    clear_in(); stall = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the core's program-counter/fetch path. Owns the program counter, the req/done run handshake and branch/jump target resolution through a writable lookup table.
- Adds relative branches, a hardware call/return stack and a configurable end address.
- Sits between the top level and instr_ROM. Control supplies the decoded branch/jump/call/ret strobes; prog_ctr drives the instruction ROM address.

Parameters:
- D, 12, program counter width in bits.
- LW, 5, lookup-table index width; table holds 2**LW entries of D bits.
- SD, 4, call/return stack depth (entries, ≥1).
- END_ADDR, 256, PC value that terminates a run.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled in IDLE and DONE.
- stall  in  1  freezes PC, stack and FSM for the cycle.
- branch_en  in  1  conditional branch strobe.
- cond  in  1  branch condition (registered zero flag); branch taken iff branch_en & cond.
- jump_en  in  1  unconditional jump.
- call_en  in  1  jump plus push of return address.
- ret_en  in  1  pop return address into PC.
- rel_mode  in  1  1: target = PC + sext(offset); 0: target = lut[target_idx].
- offset  in  8  signed relative displacement.
- target_idx  in  LW  lookup index for absolute targets.
- lut_we  in  1  table write enable.
- lut_waddr  in  LW  table write index.
- lut_wdata  in  D  table write data.
- prog_ctr  out  D  current instruction address.
- link_addr  out  D  return address (PC+1) captured at the last jump or call.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async assert, sync release): state IDLE; prog_ctr=0, link_addr=0, busy=0, done=0, stack_err=0; stack pointer=0. LUT contents are not reset.
- FSM IDLE: prog_ctr held at 0. req=1 → RUN next edge with prog_ctr=0; stack_err cleared on this edge.
- FSM RUN, busy=1:
  - Each non-stalled cycle, next PC is selected by priority ret > call > jump > taken branch > PC+1.
  - Only the highest-priority strobe acts; lower strobes that cycle are ignored.
  - req is ignored in RUN.
- Target arithmetic:
  - Relative: PC + sign-extended offset, modulo 2**D. Wraparound is legal and not flagged.
  - Absolute: lut[target_idx].
- Jump/call: link_addr ← PC+1 (mod 2**D). Call also pushes PC+1.
- Overflow: call with stack full → push dropped, PC still jumps, stack_err←1.
- Underflow: ret with stack empty → PC+1, stack_err←1.
- Termination: when the registered next PC equals END_ADDR, the FSM enters DONE on the same edge. prog_ctr shows END_ADDR, done=1, busy=0.
- FSM DONE: prog_ctr held. done stays high until req=1, which starts a new run (→ RUN, prog_ctr=0, stack emptied).
- stall=1 in RUN: all state held and strobes ignored. stall has no effect in IDLE or DONE.
- LUT write:
  - Synchronous, independent of state and stall.
  - Read is combinational; a same-cycle write to the indexed entry is not visible until the next cycle (old value used).
- Latency: one cycle from strobe to new prog_ctr. done is asserted in the cycle prog_ctr first equals END_ADDR.
- Reset mid-run: immediate return to reset values regardless of stall.

Decomposition:
- Package fetch_pkg:
  - typedef enum state_t {IDLE, RUN, DONE};
  - typedef enum next_sel_t {SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET};
  - default widths D, LW and SD as constants.
- One sub-module: ret_stack, a parametrised LIFO (depth SD, width D) with push, pop, full, empty and async active-low reset.
- The LUT stays inline as a register array.

Test Plan:
- Reset low mid-run at prog_ctr=37 → all outputs 0 immediately; after release, req=1 → prog_ctr 0,1,2 on successive edges, busy=1.
- lut[3]←0x0A0; at PC=5 jump_en=1, rel_mode=0, target_idx=3 → prog_ctr=0x0A0, link_addr=6.
- At PC=0x010, branch_en=1, rel_mode=1, offset=-4: cond=0 → 0x011; cond=1 → 0x00C. At PC=0, offset=-1 → 0xFFF (wrap).
- Nested calls at PC 10, 20, 30, 40 (SD=4), then 4 rets → returns 41, 31, 21, 11. A fifth call when full → PC jumps, stack_err=1. Ret on empty stack → PC+1, stack_err stays 1.
- Simultaneous ret_en and call_en with non-empty stack → ret wins, no push. stall=1 for 3 cycles with jump_en=1 → prog_ctr unchanged.
- END_ADDR=256, run sequentially from 250 → at 256 done=1, busy=0, PC held. req=1 → prog_ctr=0, done=0, stack_err cleared.
